dkj_input_ctrl: RTL

//  Input conditioning stage between hps_io (ps2_key, joystick_0/1) and the game core's active-low control pins.

---
 rtl/dkj_input_pkg.sv | 60 ++++++
 rtl/dkj_input_ctrl_socd.sv | 49 ++++
 rtl/dkj_input_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dkj_input_pkg.sv
// Shared definitions for the Donkey Kong Jr input conditioning slice.
// Holds PS/2 scancodes, joystick bit positions, the direction vector
// layout, the decoded-key record and the coin sequencer states.
package dkj_input_pkg;

  // Cursor keys: matched on the low byte only, so the extended flag is ignored.
  localparam logic [7:0] SC_ARROW_U = 8'h75;
  localparam logic [7:0] SC_ARROW_D = 8'h72;
  localparam logic [7:0] SC_ARROW_L = 8'h6B;
  localparam logic [7:0] SC_ARROW_R = 8'h74;

  // Remaining keys: matched on the full {extended, scancode} value.
  localparam logic [8:0] SC_J1_A   = 9'h029;
  localparam logic [8:0] SC_J1_B   = 9'h014;
  localparam logic [8:0] SC_S1_A   = 9'h005;
  localparam logic [8:0] SC_S1_B   = 9'h016;
  localparam logic [8:0] SC_S2_A   = 9'h006;
  localparam logic [8:0] SC_S2_B   = 9'h01E;
  localparam logic [8:0] SC_COIN_A = 9'h02E;
  localparam logic [8:0] SC_COIN_B = 9'h036;
  localparam logic [8:0] SC_U2     = 9'h02D;
  localparam logic [8:0] SC_D2     = 9'h02B;
  localparam logic [8:0] SC_L2     = 9'h023;
  localparam logic [8:0] SC_R2     = 9'h034;
  localparam logic [8:0] SC_J2     = 9'h01C;

  // Joystick word bit positions (same layout for both pads).
  localparam int unsigned JOY_R      = 0;
  localparam int unsigned JOY_L      = 1;
  localparam int unsigned JOY_D      = 2;
  localparam int unsigned JOY_U      = 3;
  localparam int unsigned JOY_JUMP   = 4;
  localparam int unsigned JOY_START1 = 5;
  localparam int unsigned JOY_START2 = 6;
  localparam int unsigned JOY_COIN   = 7;

  // Direction vector layout used between remap, SOCD and the pins: {U,D,L,R}.
  localparam int unsigned DIR_R = 0;
  localparam int unsigned DIR_L = 1;
  localparam int unsigned DIR_D = 2;
  localparam int unsigned DIR_U = 3;

  typedef struct packed {
    logic u1, d1, l1, r1, j1;
    logic u2, d2, l2, r2, j2;
    logic s1, s2, coin;
  } key_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } coin_state_t;

  // Horizontal cabinet orientation: U<-L, D<-R, L<-D, R<-U.
  function automatic logic [3:0] rotate_dir(input logic [3:0] dir, input logic rot);
    rotate_dir = rot ? {dir[DIR_L], dir[DIR_R], dir[DIR_D], dir[DIR_U]} : dir;
  endfunction

endpackage

// File: rtl/dkj_input_ctrl_socd.sv
// socd_resolver: per-player opposing-direction resolver, last press wins.
//   clk_sys  system clock
//   reset    synchronous active-high reset
//   dir_in   {U,D,L,R} requested directions, active high
//   dir_out  {U,D,L,R} resolved directions, active high, registered
module socd_resolver
  import dkj_input_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [3:0] dir_in,
  output logic [3:0] dir_out
);

  logic [3:0] in1, in2, pressed_new, resolved;
  logic [1:0] last_h, last_v, last_h_nxt, last_v_nxt;

  // The output uses the already-updated winner, so a fresh opposing press
  // takes effect on the same cycle it is first seen as simultaneous.
  always_comb begin
    pressed_new = in1 & ~in2;
    last_h_nxt  = last_h;
    last_v_nxt  = last_v;
    if (pressed_new[DIR_R]) last_h_nxt = 2'b01;
    if (pressed_new[DIR_L]) last_h_nxt = 2'b10;
    if (pressed_new[DIR_D]) last_v_nxt = 2'b01;
    if (pressed_new[DIR_U]) last_v_nxt = 2'b10;
    resolved = in1;
    if (in1[DIR_L] && in1[DIR_R]) {resolved[DIR_L], resolved[DIR_R]} = last_h_nxt;
    if (in1[DIR_U] && in1[DIR_D]) {resolved[DIR_U], resolved[DIR_D]} = last_v_nxt;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      in1     <= '0;
      in2     <= '0;
      last_h  <= '0;
      last_v  <= '0;
      dir_out <= '0;
    end else begin
      in1     <= dir_in;
      in2     <= in1;
      last_h  <= last_h_nxt;
      last_v  <= last_v_nxt;
      dir_out <= resolved;
    end
  end

endmodule

// File: rtl/dkj_input_ctrl.sv
// dkj_input_ctrl: conditions hps_io keyboard/joystick input for the
// dkongjr_top active-low control pins.
//   clk_sys, reset          clock, synchronous active-high reset
//   ps2_key[10:0]           [10] event toggle, [9] pressed, [8:0] ext+scancode
//   joy_0, joy_1            pads: [0]R [1]L [2]D [3]U [4]jump [5]st1 [6]st2 [7]coin
//   rotate                  1 = horizontal orientation remap
//   o_u1..o_j1, o_u2..o_j2  player controls, active low
//   o_s1, o_s2              start 1P/2P, active low
//   o_c1                    shaped coin pulse, active low
module dkj_input_ctrl
  import dkj_input_pkg::*;
#(
  parameter int unsigned COIN_HOLD = 1228800,
  parameter int unsigned COIN_GAP  = 1228800,
  parameter int unsigned CNT_W     = 24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        rotate,
  output logic        o_u1, o_d1, o_l1, o_r1, o_j1,
  output logic        o_u2, o_d2, o_l2, o_r2, o_j2,
  output logic        o_s1, o_s2,
  output logic        o_c1
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(COIN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(COIN_GAP - 1);

  logic       unused_joy_hi;
  assign unused_joy_hi = ^{joy_0[15:8], joy_1[15:8]};

  // ---------------- key decode ----------------
  logic       prev_tog;
  key_state_t keys;
  logic       key_evt, key_dn;
  logic [8:0] key_code;

  assign key_evt  = prev_tog != ps2_key[10];
  assign key_dn   = ps2_key[9];
  assign key_code = ps2_key[8:0];

  // prev_tog tracks the toggle even in reset so a toggle seen then is dropped.
  always_ff @(posedge clk_sys) begin
    prev_tog <= ps2_key[10];
    if (reset) begin
      keys <= '0;
    end else if (key_evt) begin
      case (key_code[7:0])
        SC_ARROW_U: keys.u1 <= key_dn;
        SC_ARROW_D: keys.d1 <= key_dn;
        SC_ARROW_L: keys.l1 <= key_dn;
        SC_ARROW_R: keys.r1 <= key_dn;
        default: ;
      endcase
      case (key_code)
        SC_J1_A, SC_J1_B:     keys.j1   <= key_dn;
        SC_S1_A, SC_S1_B:     keys.s1   <= key_dn;
        SC_S2_A, SC_S2_B:     keys.s2   <= key_dn;
        SC_COIN_A, SC_COIN_B: keys.coin <= key_dn;
        SC_U2:                keys.u2   <= key_dn;
        SC_D2:                keys.d2   <= key_dn;
        SC_L2:                keys.l2   <= key_dn;
        SC_R2:                keys.r2   <= key_dn;
        SC_J2:                keys.j2   <= key_dn;
        default: ;
      endcase
    end
  end

  // ---------------- directions ----------------
  logic [3:0] raw_p1, raw_p2, dir_p1, dir_p2, res_p1, res_p2;

  always_comb begin
    raw_p1 = {keys.u1 | joy_0[JOY_U], keys.d1 | joy_0[JOY_D],
              keys.l1 | joy_0[JOY_L], keys.r1 | joy_0[JOY_R]};
    raw_p2 = {keys.u2 | joy_1[JOY_U], keys.d2 | joy_1[JOY_D],
              keys.l2 | joy_1[JOY_L], keys.r2 | joy_1[JOY_R]};
    dir_p1 = rotate_dir(raw_p1, rotate);
    dir_p2 = rotate_dir(raw_p2, rotate);
  end

  socd_resolver u_socd_p1 (.clk_sys(clk_sys), .reset(reset), .dir_in(dir_p1), .dir_out(res_p1));
  socd_resolver u_socd_p2 (.clk_sys(clk_sys), .reset(reset), .dir_in(dir_p2), .dir_out(res_p2));

  assign o_u1 = ~res_p1[DIR_U];
  assign o_d1 = ~res_p1[DIR_D];
  assign o_l1 = ~res_p1[DIR_L];
  assign o_r1 = ~res_p1[DIR_R];
  assign o_u2 = ~res_p2[DIR_U];
  assign o_d2 = ~res_p2[DIR_D];
  assign o_l2 = ~res_p2[DIR_L];
  assign o_r2 = ~res_p2[DIR_R];

  // ---------------- jump / start ----------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      o_j1 <= 1'b1;
      o_j2 <= 1'b1;
      o_s1 <= 1'b1;
      o_s2 <= 1'b1;
    end else begin
      o_j1 <= ~(keys.j1 | joy_0[JOY_JUMP]);
      o_j2 <= ~(keys.j2 | joy_1[JOY_JUMP]);
      o_s1 <= ~(keys.s1 | joy_0[JOY_START1] | joy_1[JOY_START1]);
      o_s2 <= ~(keys.s2 | joy_0[JOY_START2] | joy_1[JOY_START2]);
    end
  end

  // ---------------- coin shaping ----------------
  logic              coin_req, req_q, req_qq, coin_edge;
  coin_state_t       state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [1:0]        pending_q, pending_d;

  assign coin_req  = keys.coin | joy_0[JOY_COIN] | joy_1[JOY_COIN];
  assign coin_edge = req_q & ~req_qq;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req_q     <= 1'b0;
      req_qq    <= 1'b0;
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= '0;
    end else begin
      req_q     <= coin_req;
      req_qq    <= req_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  // At the end of GAP an edge arriving with the restart keeps pending unchanged:
  // it replaces the queued pulse being consumed, or starts the pulse itself.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (coin_edge) begin
          state_d = HOLD;
          timer_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (coin_edge && pending_q != 2'd3) pending_d = pending_q + 2'd1;
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
          if (coin_edge && pending_q != 2'd3) pending_d = pending_q + 2'd1;
        end else if (pending_q != 2'd0 || coin_edge) begin
          state_d = HOLD;
          timer_d = HOLD_LOAD;
          if (!coin_edge) pending_d = pending_q - 2'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_c1 = (state_q != HOLD);

endmodule
